branch_history_table: RTL and testbench

- Table of 2-bit saturating counters, indexed by the low word-address bits of the PC.
- Lookup side: drives the 2-bit prediction-buffer value into the IF/ID-stage branch predictor in the same cycle as the fetched instruction.
- Update side: written from the branch resolution point (EX stage) with the actual BEQ outcome.
- This is the state-holding stage directly upstream of the combinational predictor.

---
 rtl/bht_pkg.sv | 17 +
 rtl/sat_counter2.sv | 30 +++
 rtl/branch_history_table.sv | 87 ++++++++
 tb/tb_branch_history_table.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared constants for the branch history table: counter encodings, index helper
// and the BEQ opcode used by the predictor and control unit.
package bht_pkg;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    localparam logic [5:0] BEQ_OPCODE = 6'b000100;

    // Word-address index: bits [index_bits+1:2] of the PC, zero-extended.
    function automatic logic [31:0] bht_index(input logic [31:0] pc, input int unsigned index_bits);
        return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state of a 2-bit saturating counter: step toward the outcome,
// holding at the end states.
module sat_counter2
    import bht_pkg::*;
(
    input  logic [1:0] cnt_in,
    input  logic       taken,
    output logic [1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (taken) begin
            unique case (cnt_in)
                BHT_SNT: cnt_out = BHT_WNT;
                BHT_WNT: cnt_out = BHT_WT;
                BHT_WT:  cnt_out = BHT_ST;
                BHT_ST:  cnt_out = BHT_ST;
            endcase
        end else begin
            unique case (cnt_in)
                BHT_SNT: cnt_out = BHT_SNT;
                BHT_WNT: cnt_out = BHT_SNT;
                BHT_WT:  cnt_out = BHT_WNT;
                BHT_ST:  cnt_out = BHT_WT;
            endcase
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating branch counters with a zero-latency lookup port and an
// EX-stage update port. Optional statistics counters are enabled by BHT_STATS_EN.
module branch_history_table
    import bht_pkg::*;
#(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_STATE = BHT_WNT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic [1:0]  lookup_counter,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_predicted,
    output logic        upd_mispredict
`ifdef BHT_STATS_EN
    ,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            table_q [ENTRIES];
    logic [31:0]           idx_l_full;
    logic [31:0]           idx_u_full;
    logic [INDEX_BITS-1:0] idx_l;
    logic [INDEX_BITS-1:0] idx_u;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_next;
    logic                  mispredict_now;
    logic                  unused_idx_bits;

    assign idx_l_full      = bht_index(lookup_pc, INDEX_BITS);
    assign idx_u_full      = bht_index(upd_pc, INDEX_BITS);
    assign idx_l           = idx_l_full[INDEX_BITS-1:0];
    assign idx_u           = idx_u_full[INDEX_BITS-1:0];
    assign unused_idx_bits = ^{idx_l_full[31:INDEX_BITS], idx_u_full[31:INDEX_BITS]};

    // No bypass: a lookup hitting the entry being updated sees the old value.
    assign lookup_counter = table_q[idx_l];
    assign ctr_cur        = table_q[idx_u];

    sat_counter2 u_sat (
        .cnt_in  (ctr_cur),
        .taken   (upd_taken),
        .cnt_out (ctr_next)
    );

    // upd_valid is a one-way strobe: the table always accepts it, there is no ready.
    // Every other update input is don't-care while upd_valid is low.
    assign mispredict_now = upd_valid & (upd_taken ^ upd_predicted);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= INIT_STATE;
            end
            upd_mispredict <= 1'b0;
        end else begin
            if (upd_valid) begin
                table_q[idx_u] <= ctr_next;
            end
            upd_mispredict <= mispredict_now;
        end
    end

`ifdef BHT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (mispredict_now) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: scoreboard queue of expected values,
// immediate-assertion checks, one summary line.
module tb_branch_history_table;
    import bht_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] lookup_pc;
    logic [1:0]  lookup_counter;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_predicted;
    logic        upd_mispredict;
`ifdef BHT_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    branch_history_table dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lookup_pc      (lookup_pc),
        .lookup_counter (lookup_counter),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_predicted  (upd_predicted),
        .upd_mispredict (upd_mispredict)
`ifdef BHT_STATS_EN
        ,
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model and scoreboard
    logic [1:0]  model [64];
    logic [31:0] m_updates;
    logic [31:0] m_mispredicts;
    logic [1:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_exp(output logic [1:0] v);
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
            v = 2'bxx;
        end else begin
            v = exp_q.pop_front();
        end
    endtask

    // Lookup check against a value pushed by the caller or taken from the model.
    task automatic look(input string tag, input logic [31:0] pc);
        logic [1:0] e;
        lookup_pc = pc;
        exp_q.push_back(model[pc[7:2]]);
        #1;
        pop_exp(e);
        check(tag, {30'd0, lookup_counter}, {30'd0, e});
    endtask

    task automatic look_const(input string tag, input logic [31:0] pc, input logic [1:0] v);
        logic [1:0] e;
        lookup_pc = pc;
        exp_q.push_back(v);
        #1;
        pop_exp(e);
        check(tag, {30'd0, lookup_counter}, {30'd0, e});
    endtask

    // One clock edge with the current inputs; model follows, then registered outputs checked.
    task automatic tick();
        logic       mis_exp;
        logic [1:0] e;
        logic [5:0] ix;
        mis_exp = rst_n && upd_valid && (upd_taken != upd_predicted);
        exp_q.push_back({1'b0, mis_exp});
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) model[i] = 2'b01;
            m_updates     = 0;
            m_mispredicts = 0;
        end else if (upd_valid) begin
            ix = upd_pc[7:2];
            if (upd_taken && model[ix] != 2'b11) model[ix] = model[ix] + 2'd1;
            else if (!upd_taken && model[ix] != 2'b00) model[ix] = model[ix] - 2'd1;
            m_updates = m_updates + 1;
            if (mis_exp) m_mispredicts = m_mispredicts + 1;
        end
        @(posedge clk);
        #1;
        pop_exp(e);
        check("upd_mispredict", {31'd0, upd_mispredict}, {31'd0, e[0]});
`ifdef BHT_STATS_EN
        check("stat_updates", stat_updates, m_updates);
        check("stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic t, input logic p);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_taken     = t;
        upd_predicted = p;
    endtask

    task automatic drive_idle();
        upd_valid     = 1'b0;
        upd_pc        = 'x;
        upd_taken     = 1'bx;
        upd_predicted = 1'bx;
    endtask

    logic [1:0] up_seq [4];
    logic [1:0] dn_seq [4];

    initial begin
        up_seq = '{2'b10, 2'b11, 2'b11, 2'b11};
        dn_seq = '{2'b10, 2'b01, 2'b00, 2'b00};
        m_updates = 0;
        m_mispredicts = 0;
        rst_n     = 1'b0;
        lookup_pc = 32'h0;
        drive_idle();

        // reset held for two cycles
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            look_const("reset_entry", 32'(4 * i), 2'b01);
        end
        tick();

        // saturate up at 0x10
        drive_upd(32'h0000_0010, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            look_const("sat_up", 32'h10, up_seq[k]);
        end

        // saturate down at 0x10, neighbour untouched
        drive_upd(32'h0000_0010, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            look_const("sat_down", 32'h10, dn_seq[k]);
            look_const("neighbour_0x14", 32'h14, 2'b01);
        end

        // aliasing and read-during-write
        drive_upd(32'h0000_0104, 1'b1, 1'b1);
        look_const("rdw_old", 32'h04, 2'b01);
        tick();
        drive_idle();
        look_const("alias_new", 32'h04, 2'b10);

        // mispredict flag
        drive_upd(32'h0000_0030, 1'b1, 1'b0);
        tick();
        drive_idle();
        tick();

        // idle cycles with garbage update inputs leave the table alone
        for (int k = 0; k < 4; k++) begin
            upd_pc    = $urandom;
            upd_taken = 1'($urandom_range(0, 1));
            tick();
        end
        look_const("idle_keep", 32'h10, 2'b00);
        look("idle_alias", 32'h04);

        // random updates over a few indices, checked against the model
        for (int k = 0; k < 40; k++) begin
            drive_upd({24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3) * 4)},
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            look("rand_lookup", 32'($urandom_range(0, 15) * 4));
            tick();
        end
        drive_idle();
        for (int k = 0; k < 4; k++) look("rand_final", 32'(k * 4));

        // reset mid-operation beats an update
        rst_n = 1'b0;
        drive_upd(32'h0000_0020, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        drive_idle();
        look_const("reset_mid_entry8", 32'h20, 2'b01);
        look_const("reset_mid_entry4", 32'h10, 2'b01);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
